buffer_occupancy_stage: RTL and testbench

//  Registered storage stage behind the buffer count logic: holds up to CAPACITY entries in age order.

---
 rtl/buffer_occupancy_stage_if.sv | 37 +++
 rtl/buffer_occupancy_stage.sv | 119 +++++++++++
 tb/tb_buffer_occupancy_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_occupancy_stage_if.sv
// rtl/buffer_occupancy_stage_if.sv - upstream/downstream entry handshake bundle for the occupancy stage
interface buffer_occupancy_stage_if #(
    parameter int MAX_IN  = 4,
    parameter int MAX_OUT = 4,
    parameter int WIDTH   = 16
);
    logic [7:0]               prevSending;
    logic [MAX_IN*WIDTH-1:0]  dataIn;
    logic [7:0]               accepting;
    logic [7:0]               nextAccepting;
    logic [MAX_OUT*WIDTH-1:0] dataOut;
    logic [MAX_OUT-1:0]       outValid;
    logic [7:0]               wantSend;
    logic [7:0]               sending;

    modport master (
        output prevSending,
        output dataIn,
        output nextAccepting,
        input  accepting,
        input  dataOut,
        input  outValid,
        input  wantSend,
        input  sending
    );

    modport slave (
        input  prevSending,
        input  dataIn,
        input  nextAccepting,
        output accepting,
        output dataOut,
        output outValid,
        output wantSend,
        output sending
    );
endinterface

// File: rtl/buffer_occupancy_stage.sv
// rtl/buffer_occupancy_stage.sv - age-ordered entry store with per-cycle kill, send and accept counts
module buffer_occupancy_stage #(
    parameter int CAPACITY = 8,
    parameter int MAX_IN   = 4,
    parameter int MAX_OUT  = 4,
    parameter int WIDTH    = 16
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       lockAccept,
    input  logic       lockSend,
    input  logic       killAll,
    input  logic [7:0] kill,
    output logic [7:0] full,
    output logic [7:0] living,
    output logic       overflow,
    buffer_occupancy_stage_if.slave bus
);
    localparam logic [7:0] CAP8 = 8'(CAPACITY);
    localparam logic [7:0] IN8  = 8'(MAX_IN);
    localparam logic [7:0] OUT8 = 8'(MAX_OUT);

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [WIDTH-1:0] slots     [CAPACITY];
    logic [WIDTH-1:0] slotsNext [CAPACITY];
    // Zero-padded view so a shift by up to MAX_OUT never reads past the last slot.
    logic [WIDTH-1:0] slotsExt  [CAPACITY+MAX_OUT];

    logic [7:0] wantSend;
    logic [7:0] sending;
    logic [7:0] afterSending;
    logic [7:0] canAccept;
    logic [7:0] accepting;
    logic [7:0] taken;
    logic [7:0] fullNext;

    always_comb begin
        living = 8'd0;
        if (!killAll && (kill < full)) begin
            living = full - kill;
        end
        wantSend     = lockSend ? 8'd0 : min8(OUT8, living);
        sending      = min8(bus.nextAccepting, wantSend);
        afterSending = living - sending;
        canAccept    = lockAccept ? 8'd0 : min8(IN8, CAP8);
        accepting    = min8(canAccept, CAP8 - afterSending);
        taken        = min8(bus.prevSending, accepting);
        fullNext     = afterSending + taken;
    end

    always_comb begin
        for (int i = 0; i < CAPACITY + MAX_OUT; i++) begin
            slotsExt[i] = '0;
        end
        for (int i = 0; i < CAPACITY; i++) begin
            slotsExt[i] = slots[i];
        end
    end

    always_comb begin
        int afterI;
        int sendI;
        int takenI;
        afterI = int'(afterSending);
        sendI  = int'(sending);
        takenI = int'(taken);
        for (int i = 0; i < CAPACITY; i++) begin
            slotsNext[i] = slots[i];
            if (i < afterI) begin
                for (int s = 0; s <= MAX_OUT; s++) begin
                    if (sendI == s) begin
                        slotsNext[i] = slotsExt[i+s];
                    end
                end
            end else begin
                // New entries land directly behind the survivors, lane 0 first.
                for (int j = 0; j < MAX_IN; j++) begin
                    if ((i - afterI == j) && (j < takenI)) begin
                        slotsNext[i] = bus.dataIn[j*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            full     <= 8'd0;
            overflow <= 1'b0;
            for (int i = 0; i < CAPACITY; i++) begin
                slots[i] <= '0;
            end
        end else begin
            full <= fullNext;
            if (bus.prevSending > accepting) begin
                overflow <= 1'b1;
            end
            for (int i = 0; i < CAPACITY; i++) begin
                slots[i] <= slotsNext[i];
            end
        end
    end

    always_comb begin
        bus.dataOut  = '0;
        bus.outValid = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            bus.dataOut[i*WIDTH +: WIDTH] = slots[i];
            bus.outValid[i]               = (i < int'(wantSend));
        end
    end

    assign bus.wantSend  = wantSend;
    assign bus.sending   = sending;
    assign bus.accepting = accepting;
endmodule

// File: tb/tb_buffer_occupancy_stage.sv
// tb/tb_buffer_occupancy_stage.sv - directed self-checking bench for buffer_occupancy_stage
module tb_buffer_occupancy_stage;
    localparam int CAPACITY = 8;
    localparam int MAX_IN   = 4;
    localparam int MAX_OUT  = 4;
    localparam int WIDTH    = 16;

    logic       clk = 1'b0;
    logic       resetN;
    logic       lockAccept;
    logic       lockSend;
    logic       killAll;
    logic [7:0] kill;
    logic [7:0] full;
    logic [7:0] living;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    buffer_occupancy_stage_if #(.MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .WIDTH(WIDTH)) bus ();

    buffer_occupancy_stage #(
        .CAPACITY(CAPACITY), .MAX_IN(MAX_IN), .MAX_OUT(MAX_OUT), .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .lockAccept(lockAccept),
        .lockSend  (lockSend),
        .killAll   (killAll),
        .kill      (kill),
        .full      (full),
        .living    (living),
        .overflow  (overflow),
        .bus       (bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] laneOut(input int i);
        return bus.dataOut[i*WIDTH +: WIDTH];
    endfunction

    task automatic idle();
        lockAccept        = 1'b0;
        lockSend          = 1'b0;
        killAll           = 1'b0;
        kill              = 8'd0;
        bus.prevSending   = 8'd0;
        bus.nextAccepting = 8'd0;
        bus.dataIn        = '0;
    endtask

    task automatic present(input int n, input logic [15:0] base);
        bus.prevSending = 8'(n);
        for (int j = 0; j < MAX_IN; j++) begin
            bus.dataIn[j*WIDTH +: WIDTH] = (j < n) ? base + 16'(j) : 16'h0000;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkLanes(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] e2, input logic [15:0] e3);
        check({tag, "_lane0"}, 32'(laneOut(0)), 32'(e0));
        check({tag, "_lane1"}, 32'(laneOut(1)), 32'(e1));
        check({tag, "_lane2"}, 32'(laneOut(2)), 32'(e2));
        check({tag, "_lane3"}, 32'(laneOut(3)), 32'(e3));
    endtask

    initial begin
        idle();
        resetN = 1'b0;
        #2;
        resetN = 1'b1;

        // build stale state including a sticky overflow, then reset asynchronously
        present(5, 16'h5000);
        tick();
        check("stale_full", 32'(full), 32'd4);
        check("stale_overflow", 32'(overflow), 32'd1);
        idle();
        #2;
        resetN = 1'b0;
        #1;
        check("reset_full", 32'(full), 32'd0);
        check("reset_outValid", 32'(bus.outValid), 32'd0);
        check("reset_accepting", 32'(bus.accepting), 32'd4);
        check("reset_overflow", 32'(overflow), 32'd0);
        #3;
        resetN = 1'b1;
        tick();

        // fill with A0..A7
        present(4, 16'hA000);
        #1;
        check("fill1_accepting", 32'(bus.accepting), 32'd4);
        tick();
        check("fill1_full", 32'(full), 32'd4);
        present(4, 16'hA004);
        #1;
        check("fill2_accepting", 32'(bus.accepting), 32'd4);
        tick();
        idle();
        #1;
        check("fill_full", 32'(full), 32'd8);
        check("fill_accepting", 32'(bus.accepting), 32'd0);
        check("fill_wantSend", 32'(bus.wantSend), 32'd4);
        check("fill_outValid", 32'(bus.outValid), 32'hF);
        checkLanes("fill", 16'hA000, 16'hA001, 16'hA002, 16'hA003);

        // simultaneous drain of 3 and refill with B0..B2
        bus.nextAccepting = 8'd3;
        present(3, 16'hB000);
        #1;
        check("drain_sending", 32'(bus.sending), 32'd3);
        check("drain_accepting", 32'(bus.accepting), 32'd3);
        tick();
        idle();
        #1;
        check("drain_full", 32'(full), 32'd8);
        checkLanes("drain", 16'hA003, 16'hA004, 16'hA005, 16'hA006);

        // send 3 more to reach full=5: A6 A7 B0 B1 B2
        bus.nextAccepting = 8'd3;
        tick();
        idle();
        check("pre_kill_full", 32'(full), 32'd5);
        kill = 8'd2;
        #1;
        check("kill_living", 32'(living), 32'd3);
        tick();
        idle();
        #1;
        check("kill_full", 32'(full), 32'd3);
        check("kill_outValid", 32'(bus.outValid), 32'h7);
        check("kill_lane0", 32'(laneOut(0)), 32'hA006);
        check("kill_lane2", 32'(laneOut(2)), 32'hB000);
        kill = 8'd7;
        #1;
        check("killclamp_living", 32'(living), 32'd0);
        check("killclamp_wantSend", 32'(bus.wantSend), 32'd0);
        tick();
        idle();
        check("killclamp_full", 32'(full), 32'd0);

        // killAll while upstream delivers D0,D1
        present(4, 16'hC000);
        tick();
        present(2, 16'hC004);
        tick();
        idle();
        check("pre_killall_full", 32'(full), 32'd6);
        killAll = 1'b1;
        bus.nextAccepting = 8'd4;
        present(2, 16'hD000);
        #1;
        check("killall_sending", 32'(bus.sending), 32'd0);
        check("killall_accepting", 32'(bus.accepting), 32'd4);
        tick();
        idle();
        #1;
        check("killall_full", 32'(full), 32'd2);
        check("killall_outValid", 32'(bus.outValid), 32'h3);
        check("killall_lane0", 32'(laneOut(0)), 32'hD000);
        check("killall_lane1", 32'(laneOut(1)), 32'hD001);
        check("killall_overflow", 32'(overflow), 32'd0);

        // overflow: full=7, three offered, one accepted
        present(4, 16'hE000);
        tick();
        present(1, 16'hE004);
        tick();
        idle();
        check("pre_ovf_full", 32'(full), 32'd7);
        present(3, 16'hF000);
        #1;
        check("ovf_accepting", 32'(bus.accepting), 32'd1);
        tick();
        idle();
        #1;
        check("ovf_full", 32'(full), 32'd8);
        check("ovf_overflow", 32'(overflow), 32'd1);
        checkLanes("ovf", 16'hD000, 16'hD001, 16'hE000, 16'hE001);
        tick();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // locks, and nextAccepting above wantSend clamps
        lockSend = 1'b1;
        bus.nextAccepting = 8'd4;
        #1;
        check("lockSend_wantSend", 32'(bus.wantSend), 32'd0);
        check("lockSend_sending", 32'(bus.sending), 32'd0);
        check("lockSend_outValid", 32'(bus.outValid), 32'd0);
        lockSend = 1'b0;
        lockAccept = 1'b1;
        bus.nextAccepting = 8'd9;
        #1;
        check("clamp_sending", 32'(bus.sending), 32'd4);
        check("lockAccept_accepting", 32'(bus.accepting), 32'd0);
        tick();
        idle();
        #1;
        check("clamp_full", 32'(full), 32'd4);
        checkLanes("clamp", 16'hE002, 16'hE003, 16'hE004, 16'hF000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
